ibex_pext_mult_seq: RTL and testbench

Sequencer for the P-extension SIMD multiplier datapath. Accepts one decoded multiply request at a time and steps the shared 8x8-kernel array through its passes: LOWER, optional UPPER for 32x32, optional ACCUM. Merges the partial products, applies optional rounding and saturating accumulation, and returns a 32-bit result with an overflow flag over a valid/ready handshake. Sits between the EX-stage P-extension decoder and the multiplier array.

---
 rtl/ibex_pext_mult_seq.sv | 168 ++++++++++++++++
 tb/tb_ibex_pext_mult_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_pext_mult_seq.sv
// rtl/ibex_pext_mult_seq.sv - P-extension SIMD multiplier pass sequencer; rounding enabled by IBEX_PEXT_MULT_ROUND_EN
module ibex_pext_mult_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  op_mode_i,
  input  logic        op_crossed_i,
  input  logic        op_accum_i,
  input  logic        op_sub_i,
  input  logic        op_round_i,
  input  logic [31:0] rd_val_i,
  input  logic        kill_i,
  output logic        mult_en_o,
  output logic [1:0]  mult_quadrant_o,
  input  logic [47:0] mult_prod_i,
  input  logic        mult_sat_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] result_o,
  output logic        ov_o
);

  typedef enum logic [2:0] {IDLE, LOWER, UPPER, ACCUM, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  mode_q;
  logic        crossed_q, accum_q, sub_q;
  logic [31:0] rd_q, result_q;
  logic [47:0] prod_lo_q;
  logic        sat_q;
  logic        accept;
  logic [47:0] lo_src, sum_hi, sum_mid;
  logic [31:0] res_raw, acc_res;
  logic [32:0] acc_sum;
  logic        acc_ov;
  logic [31:0] unused_low;

  assign accept = (state_q == IDLE) && req_valid_i && !kill_i;

  // In UPPER the low pass is already registered and the port carries the high pass.
  assign lo_src = (state_q == UPPER) ? prod_lo_q : mult_prod_i;

  // sum_hi is bits [63:16] of sext(lo) + (sext(hi) << 16); the low 16 bits pass through untouched.
`ifdef IBEX_PEXT_MULT_ROUND_EN
  logic round_q;
  assign sum_hi  = {{16{lo_src[47]}}, lo_src[47:16]} + mult_prod_i + {32'b0, round_q, 15'b0};
  assign sum_mid = lo_src + {32'b0, round_q, 15'b0};
`else
  logic unused_round;
  assign unused_round = op_round_i;
  assign sum_hi  = {{16{lo_src[47]}}, lo_src[47:16]} + mult_prod_i;
  assign sum_mid = lo_src;
`endif

  assign unused_low = {sum_hi[15:0], sum_mid[15:0]};

  // Merge partial products into the 32-bit result slice for the registered mode.
  always_comb begin
    res_raw = lo_src[31:0];
    case (mode_q)
      2'b11:   res_raw = sum_hi[47:16];
      2'b10:   res_raw = sum_mid[47:16];
      default: res_raw = lo_src[31:0];
    endcase
  end

  // Saturating accumulate of the registered raw result into rd.
  always_comb begin
    acc_sum = sub_q ? ({rd_q[31], rd_q} - {result_q[31], result_q})
                    : ({rd_q[31], rd_q} + {result_q[31], result_q});
    acc_ov  = acc_sum[32] ^ acc_sum[31];
    acc_res = acc_ov ? (acc_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : acc_sum[31:0];
  end

  // Next-state and pass-control outputs; kill overrides every busy state.
  always_comb begin
    state_d         = state_q;
    req_ready_o     = 1'b0;
    mult_en_o       = 1'b0;
    mult_quadrant_o = 2'b00;
    res_valid_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = !kill_i;
        if (accept) state_d = LOWER;
      end
      LOWER: begin
        mult_en_o = 1'b1;
        case (mode_q)
          2'b00:   mult_quadrant_o = 2'b00;
          2'b01:   mult_quadrant_o = crossed_q ? 2'b11 : 2'b00;
          2'b10:   mult_quadrant_o = crossed_q ? 2'b01 : 2'b10;
          default: mult_quadrant_o = 2'b10;
        endcase
        if (mode_q == 2'b11) state_d = UPPER;
        else if (accum_q)    state_d = ACCUM;
        else                 state_d = DONE;
      end
      UPPER: begin
        mult_en_o       = 1'b1;
        mult_quadrant_o = 2'b01;
        state_d         = accum_q ? ACCUM : DONE;
      end
      ACCUM: state_d = DONE;
      DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (kill_i && (state_q != IDLE)) state_d = IDLE;
  end

  // State, captured operands, partial product, result and sticky saturation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      mode_q    <= 2'b00;
      crossed_q <= 1'b0;
      accum_q   <= 1'b0;
      sub_q     <= 1'b0;
      rd_q      <= '0;
      prod_lo_q <= '0;
      result_q  <= '0;
      sat_q     <= 1'b0;
`ifdef IBEX_PEXT_MULT_ROUND_EN
      round_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q    <= op_mode_i;
        crossed_q <= op_crossed_i;
        accum_q   <= op_accum_i;
        sub_q     <= op_sub_i & op_accum_i;
        rd_q      <= rd_val_i;
        sat_q     <= 1'b0;
`ifdef IBEX_PEXT_MULT_ROUND_EN
        round_q   <= op_round_i;
`endif
      end else if (kill_i && (state_q != IDLE)) begin
        sat_q <= 1'b0;
      end else begin
        case (state_q)
          LOWER: begin
            prod_lo_q <= mult_prod_i;
            sat_q     <= sat_q | mult_sat_i;
            if (mode_q != 2'b11) result_q <= res_raw;
          end
          UPPER: begin
            sat_q    <= sat_q | mult_sat_i;
            result_q <= res_raw;
          end
          ACCUM: begin
            sat_q    <= sat_q | acc_ov;
            result_q <= acc_res;
          end
          default: ;
        endcase
      end
    end
  end

  assign result_o = result_q;
  assign ov_o     = sat_q;

endmodule

// File: tb/tb_ibex_pext_mult_seq.sv
// tb/tb_ibex_pext_mult_seq.sv - randomized self-checking bench for ibex_pext_mult_seq
module tb_ibex_pext_mult_seq;

`ifdef IBEX_PEXT_MULT_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0]  mode;
    logic        crossed, accum, sub, round;
    logic [31:0] rd;
    logic [47:0] lo, hi;
    logic        slo, shi;
    int          rdy_dly;
    int          kill_at;
    int          rst_at;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  op_mode = 2'b00;
  logic        op_crossed = 1'b0, op_accum = 1'b0, op_sub = 1'b0, op_round = 1'b0;
  logic [31:0] rd_val = '0;
  logic        kill = 1'b0;
  logic        mult_en;
  logic [1:0]  mult_quad;
  logic [47:0] mult_prod;
  logic        mult_sat;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] result;
  logic        ov;

  // datapath stand-in: pass values the bench chose for the current operation
  logic [1:0]  cur_mode = 2'b00;
  logic [47:0] cur_lo = '0, cur_hi = '0;
  logic        cur_slo = 1'b0, cur_shi = 1'b0;

  // per-cycle expectations
  logic        chk_on = 1'b0;
  logic        exp_ready = 1'b1, exp_en = 1'b0, exp_valid = 1'b0, exp_ov = 1'b0, exp_rst_chk = 1'b0;
  logic [1:0]  exp_quad = 2'b00;
  logic [31:0] exp_result = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mult_prod = (cur_mode == 2'b11 && mult_quad == 2'b01) ? cur_hi : cur_lo;
  assign mult_sat  = (cur_mode == 2'b11 && mult_quad == 2'b01) ? cur_shi : cur_slo;

  ibex_pext_mult_seq dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_mode_i(op_mode), .op_crossed_i(op_crossed), .op_accum_i(op_accum),
    .op_sub_i(op_sub), .op_round_i(op_round), .rd_val_i(rd_val), .kill_i(kill),
    .mult_en_o(mult_en), .mult_quadrant_o(mult_quad), .mult_prod_i(mult_prod),
    .mult_sat_i(mult_sat), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .result_o(result), .ov_o(ov)
  );

  function automatic op_t mk(input logic [1:0] mode, input logic crossed, accum, sub, round,
                             input logic [31:0] rd, input logic [47:0] lo, hi);
    op_t o;
    o.mode = mode; o.crossed = crossed; o.accum = accum; o.sub = sub; o.round = round;
    o.rd = rd; o.lo = lo; o.hi = hi; o.slo = 1'b0; o.shi = 1'b0;
    o.rdy_dly = 0; o.kill_at = -1; o.rst_at = -1;
    return o;
  endfunction

  // 32x32 decomposition: lo = A * unsigned(B[15:0]), hi = A * signed(B[31:16])
  function automatic void split(input logic [31:0] a, b, output logic [47:0] lo, hi);
    longint sa, pl, ph;
    sa = $signed({{32{a[31]}}, a});
    pl = sa * $signed({48'b0, b[15:0]});
    ph = sa * $signed({{48{b[31]}}, b[31:16]});
    lo = pl[47:0];
    hi = ph[47:0];
  endfunction

  // {ov, result} from the arithmetic definition of the operation
  function automatic logic [32:0] model(input op_t o);
    longint slo, shi, f, s, r64;
    logic [31:0] r;
    logic ov_m, rnd;
    rnd  = o.round & ROUND_EN;
    slo  = $signed({{16{o.lo[47]}}, o.lo});
    shi  = $signed({{16{o.hi[47]}}, o.hi});
    ov_m = o.slo | ((o.mode == 2'b11) & o.shi);
    f    = 0;
    case (o.mode)
      2'b11: begin
        f = slo + shi * 65536 + (rnd ? 64'sh8000_0000 : 64'sh0);
        r = f[63:32];
      end
      2'b10: begin
        f = slo + (rnd ? 64'sh8000 : 64'sh0);
        r = f[47:16];
      end
      default: r = o.lo[31:0];
    endcase
    if (o.accum) begin
      s   = $signed({{32{o.rd[31]}}, o.rd});
      r64 = $signed({{32{r[31]}}, r});
      s   = o.sub ? s - r64 : s + r64;
      if (s > 64'sh7FFF_FFFF) begin
        r = 32'h7FFF_FFFF; ov_m = 1'b1;
      end else if (s < -64'sh8000_0000) begin
        r = 32'h8000_0000; ov_m = 1'b1;
      end else begin
        r = s[31:0];
      end
    end
    return {ov_m, r};
  endfunction

  function automatic logic [1:0] q_lower(input logic [1:0] mode, input logic crossed);
    case (mode)
      2'b00:   return 2'b00;
      2'b01:   return crossed ? 2'b11 : 2'b00;
      2'b10:   return crossed ? 2'b01 : 2'b10;
      default: return 2'b10;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    exp_ready = !kill; exp_en = 1'b0; exp_quad = 2'b00; exp_valid = 1'b0;
  endtask

  // Runs one operation from request to handshake (or kill/reset); returns at posedge+1 with DUT idle.
  task automatic run_op(input op_t o);
    logic [32:0] m;
    int ph[4];
    int nph;
    logic aborted;
    m = model(o);
    nph = 1; ph[0] = 0;
    if (o.mode == 2'b11) begin ph[nph] = 1; nph++; end
    if (o.accum)         begin ph[nph] = 2; nph++; end
    ph[nph] = 3; nph++;
    cur_mode = o.mode; cur_lo = o.lo; cur_hi = o.hi; cur_slo = o.slo; cur_shi = o.shi;
    req_valid = 1'b1; op_mode = o.mode; op_crossed = o.crossed; op_accum = o.accum;
    op_sub = o.sub; op_round = o.round; rd_val = o.rd;
    exp_rst_chk = 1'b0;
    set_idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
    op_mode = 2'($urandom); op_crossed = 1'($urandom); op_accum = 1'($urandom);
    op_sub = 1'($urandom); op_round = 1'($urandom); rd_val = $urandom;
    aborted = 1'b0;
    for (int i = 0; i < nph; i++) begin
      exp_ready  = 1'b0;
      exp_en     = (ph[i] < 2);
      exp_quad   = (ph[i] == 0) ? q_lower(o.mode, o.crossed) : ((ph[i] == 1) ? 2'b01 : 2'b00);
      exp_valid  = (ph[i] == 3);
      exp_result = m[31:0];
      exp_ov     = m[32];
      kill = (o.kill_at == i);
      rst  = (o.rst_at == i);
      if (ph[i] == 3 && !kill && !rst) begin
        res_ready = 1'b0;
        repeat (o.rdy_dly) begin @(posedge clk); #1; end
        res_ready = 1'b1;
      end
      @(posedge clk); #1;
      res_ready = 1'b0;
      if (kill || rst) begin
        exp_rst_chk = rst;
        aborted = 1'b1;
        kill = 1'b0; rst = 1'b0;
        break;
      end
    end
    set_idle();
    if (aborted) begin
      @(posedge clk); #1;
      exp_rst_chk = 1'b0;
    end
  endtask

  task automatic kill_idle();
    req_valid = 1'b1; kill = 1'b1; op_mode = 2'b00; cur_mode = 2'b00;
    set_idle();
    @(posedge clk); #1;
    req_valid = 1'b0; kill = 1'b0;
    set_idle();
    @(posedge clk); #1;
  endtask

  // compare process: pins the model with literals, then checks the DUT every cycle
  initial begin : compare
    op_t t;
    logic [47:0] l, h;
    logic [32:0] m;
    t = mk(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 48'h0000_0000_1234, 48'h0);
    m = model(t); chk("model_16x16", m, {1'b0, 32'h0000_1234});
    split(32'h7FFF_FFFF, 32'h7FFF_FFFF, l, h);
    t = mk(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, l, h);
    m = model(t); chk("model_32x32", m, {1'b0, 32'h3FFF_FFFF});
    t = mk(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFF0, 48'h0001_0000_00, 48'h0);
    m = model(t); chk("model_acc_sat", m, {1'b1, 32'h7FFF_FFFF});
    t = mk(2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 48'h0001_0000_00, 48'h0);
    m = model(t); chk("model_sub_sat", m, {1'b1, 32'h8000_0000});
    t = mk(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 48'h0000_0001_8000, 48'h0);
    m = model(t); chk("model_round", m, {1'b0, ROUND_EN ? 32'h2 : 32'h1});
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("req_ready", req_ready, exp_ready);
        chk("mult_en", mult_en, exp_en);
        chk("mult_quadrant", mult_quad, exp_quad);
        chk("res_valid", res_valid, exp_valid);
        if (exp_valid) begin
          chk("result", result, exp_result);
          chk("ov", ov, exp_ov);
        end
        if (exp_rst_chk) begin
          chk("reset_result", result, 32'h0);
          chk("reset_ov", ov, 1'b0);
        end
      end
    end
  end

  initial begin : stim
    op_t o;
    logic [47:0] l, h;
    int sel;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; exp_rst_chk = 1'b1; set_idle(); chk_on = 1'b1;
    @(posedge clk); #1;
    exp_rst_chk = 1'b0;

    run_op(mk(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 48'h0000_0000_1234, 48'h0));
    run_op(mk(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 48'h0000_0000_5678, 48'h0));
    split(32'h7FFF_FFFF, 32'h7FFF_FFFF, l, h);
    run_op(mk(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, l, h));
    run_op(mk(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFF0, 48'h0001_0000_00, 48'h0));
    run_op(mk(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 48'h0001_0000_00, 48'h0));
    run_op(mk(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 48'h0000_0001_8000, 48'h0));
    o = mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 48'h0000_8182_8384, 48'h0);
    o.rdy_dly = 5; o.slo = 1'b1;
    run_op(o);
    o = mk(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, l, h);
    o.kill_at = 1;
    run_op(o);
    kill_idle();
    o = mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 48'h0000_0000_0101, 48'h0);
    o.rst_at = 1;
    run_op(o);
    run_op(mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 48'h0000_0000_0101, 48'h0));

    for (int n = 0; n < 80; n++) begin
      o = mk(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom, {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)});
      sel = int'($urandom_range(0, 3));
      if (sel == 0) o.rd = 32'h7FFF_FFF0;
      else if (sel == 1) o.rd = 32'h8000_0010;
      o.slo = ($urandom_range(0, 7) == 0);
      o.shi = ($urandom_range(0, 7) == 0);
      o.rdy_dly = int'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) o.kill_at = int'($urandom_range(0, 3));
      run_op(o);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
